demux_bank: RTL and testbench

DEMUX_BANK -- requirements
Module: demux_bank

---
 rtl/demux_bank.sv | 133 +++++++++++++
 tb/tb_demux_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_bank.sv
// demux_bank -- distributes input words into four slot registers.
//
// A producer presents D with a destination slot M and in_valid. A word is
// taken on a rising edge when in_valid and in_ready are both high. in_ready
// is low whenever the addressed slot already holds a word, so a loaded slot
// is never overwritten and the producer stalls instead. Once all four slots
// are loaded the bank stays LOADED until the consumer pulses consume, which
// clears the loaded flags but leaves the slot data in place.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   D          in   WIDTH  data word to distribute
//   M          in   2      destination slot select
//   in_valid   in   1      producer has a valid D/M
//   in_ready   out  1      addressed slot is free (combinational on M, full)
//   out0..out3 out  WIDTH  slot registers
//   full       out  4      per-slot loaded flags
//   fill_count out  3      number of loaded slots, 0..4
//   all_full   out  1      all four slots loaded
//   done       out  1      one-cycle pulse after the bank becomes loaded
//   consume    in   1      release a fully loaded bank
module demux_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       M,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       full,
  output logic [2:0]       fill_count,
  output logic             all_full,
  output logic             done,
  input  logic             consume
);

  // Bank state is derived from the loaded-slot count rather than stored.
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_LOADED  = 2'd2;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  logic [WIDTH-1:0] slot_q [4];
  logic [WIDTH-1:0] slot_d [4];
  logic [3:0]       full_q, full_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [1:0]       state_s;
  logic             ready_s;
  logic             xfer_s;

  // Decode the bank state from the registered count.
  always_comb begin
    case (cnt_q)
      3'd0:    state_s = ST_EMPTY;
      3'd4:    state_s = ST_LOADED;
      default: state_s = ST_FILLING;
    endcase
  end

  // Ready tracks the addressed slot; in LOADED every slot is full, so it is 0.
  always_comb begin
    ready_s = ~full_q[M];
    xfer_s  = in_valid & ready_s;
  end

  // Next-state: load one slot on a transfer, or clear the flags on consume.
  always_comb begin
    full_d = full_q;
    slot_d = slot_q;
    case (state_s)
      ST_LOADED: begin
        if (consume) begin
          full_d = 4'b0000;
        end else begin
          full_d = full_q;
        end
      end
      ST_EMPTY, ST_FILLING: begin
        if (xfer_s) begin
          full_d    = full_q | (4'b0001 << M);
          slot_d[M] = D;
        end else begin
          full_d = full_q;
        end
      end
      default: full_d = full_q;
    endcase
    cnt_d  = popcount4(full_d);
    // Only the edge that enters LOADED produces a done pulse.
    done_d = (cnt_d == 3'd4) && (state_s != ST_LOADED);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= '0;
      end
      full_q <= 4'b0000;
      cnt_q  <= 3'd0;
      done_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      full_q <= full_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Output mapping.
  always_comb begin
    in_ready   = ready_s;
    out0       = slot_q[0];
    out1       = slot_q[1];
    out2       = slot_q[2];
    out3       = slot_q[3];
    full       = full_q;
    fill_count = cnt_q;
    all_full   = (cnt_q == 3'd4);
    done       = done_q;
  end

endmodule

// File: tb/tb_demux_bank.sv
module tb_demux_bank;

  logic        clk;
  logic        rst_n;
  logic [15:0] d_r;
  logic [1:0]  m_r;
  logic        valid_r;
  logic        consume_r;
  logic        in_ready;
  logic [15:0] out0, out1, out2, out3;
  logic [3:0]  full;
  logic [2:0]  fill_count;
  logic        all_full;
  logic        done;

  demux_bank #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .D(d_r), .M(m_r), .in_valid(valid_r),
    .in_ready(in_ready), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .full(full), .fill_count(fill_count), .all_full(all_full), .done(done),
    .consume(consume_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: slot contents and loaded flags
  logic [15:0] mout [4];
  logic [3:0]  mfull;
  logic        mdone;
  logic        last_rdy;

  typedef struct {
    logic        v;
    logic [1:0]  m;
    logic [15:0] d;
    logic        c;
    logic        exp_rdy;
    logic [3:0]  exp_full;
    logic [2:0]  exp_cnt;
    logic        exp_done;
    logic [63:0] exp_outs;   // {out3,out2,out1,out0}
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mcount();
    int n = 0;
    for (int i = 0; i < 4; i++) if (mfull[i]) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mout[i] = 16'h0000;
    mfull = 4'b0000;
    mdone = 1'b0;
  endtask

  task automatic check_model();
    chk("full", {60'd0, full}, {60'd0, mfull});
    chk("fill_count", {61'd0, fill_count}, 64'(mcount()));
    chk("all_full", {63'd0, all_full}, {63'd0, (mcount() == 4)});
    chk("done", {63'd0, done}, {63'd0, mdone});
    chk("out0", {48'd0, out0}, {48'd0, mout[0]});
    chk("out1", {48'd0, out1}, {48'd0, mout[1]});
    chk("out2", {48'd0, out2}, {48'd0, mout[2]});
    chk("out3", {48'd0, out3}, {48'd0, mout[3]});
  endtask

  // Drive one cycle of inputs, step the model, compare after the edge.
  task automatic apply(input logic v, input logic [1:0] m, input logic [15:0] d, input logic c);
    logic [3:0] nf;
    valid_r = v; m_r = m; d_r = d; consume_r = c;
    #1;
    last_rdy = in_ready;
    chk("in_ready", {63'd0, in_ready}, {63'd0, !mfull[m]});
    nf = mfull;
    if (mfull == 4'hF) begin
      if (c) nf = 4'h0;
    end else if (v && !mfull[m]) begin
      nf[m] = 1'b1;
      mout[m] = d;
    end
    mdone = (nf == 4'hF) && (mfull != 4'hF);
    mfull = nf;
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_outs"}, {out3, out2, out1, out0}, 64'd0);
    chk({tag, "_full"}, {60'd0, full}, 64'd0);
    chk({tag, "_cnt"}, {61'd0, fill_count}, 64'd0);
    chk({tag, "_all_full"}, {63'd0, all_full}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic do_reset();
    valid_r = 1'b0; consume_r = 1'b0; m_r = 2'd0; d_r = 16'h0;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] m, input logic [15:0] d,
                              input logic c, input logic rdy, input logic [3:0] f,
                              input logic [2:0] n, input logic dn, input logic [63:0] o);
    vec_t t;
    t.v = v; t.m = m; t.d = d; t.c = c; t.exp_rdy = rdy; t.exp_full = f;
    t.exp_cnt = n; t.exp_done = dn; t.exp_outs = o;
    return t;
  endfunction

  initial begin
    int pulses;
    tv[0]  = mk(1, 2'd0, 16'h1111, 0, 1, 4'b0001, 3'd1, 0, 64'h0000_0000_0000_1111);
    tv[1]  = mk(1, 2'd1, 16'h2222, 0, 1, 4'b0011, 3'd2, 0, 64'h0000_0000_2222_1111);
    tv[2]  = mk(1, 2'd2, 16'h3333, 0, 1, 4'b0111, 3'd3, 0, 64'h0000_3333_2222_1111);
    tv[3]  = mk(1, 2'd3, 16'h4444, 0, 1, 4'b1111, 3'd4, 1, 64'h4444_3333_2222_1111);
    tv[4]  = mk(0, 2'd0, 16'h0000, 0, 0, 4'b1111, 3'd4, 0, 64'h4444_3333_2222_1111);
    tv[5]  = mk(1, 2'd0, 16'h9999, 0, 0, 4'b1111, 3'd4, 0, 64'h4444_3333_2222_1111);
    tv[6]  = mk(0, 2'd0, 16'h0000, 1, 0, 4'b0000, 3'd0, 0, 64'h4444_3333_2222_1111);
    tv[7]  = mk(1, 2'd2, 16'hAAAA, 0, 1, 4'b0100, 3'd1, 0, 64'h4444_AAAA_2222_1111);
    tv[8]  = mk(1, 2'd2, 16'hBBBB, 0, 0, 4'b0100, 3'd1, 0, 64'h4444_AAAA_2222_1111);
    tv[9]  = mk(1, 2'd0, 16'hBBBB, 0, 1, 4'b0101, 3'd2, 0, 64'h4444_AAAA_2222_BBBB);
    tv[10] = mk(0, 2'd0, 16'h0000, 1, 0, 4'b0101, 3'd2, 0, 64'h4444_AAAA_2222_BBBB);
    tv[11] = mk(1, 2'd1, 16'hCCCC, 0, 1, 4'b0111, 3'd3, 0, 64'h4444_AAAA_CCCC_BBBB);
    tv[12] = mk(1, 2'd3, 16'hDDDD, 0, 1, 4'b1111, 3'd4, 1, 64'hDDDD_AAAA_CCCC_BBBB);
    tv[13] = mk(1, 2'd3, 16'h5A5A, 1, 0, 4'b0000, 3'd0, 0, 64'hDDDD_AAAA_CCCC_BBBB);
    tv[14] = mk(1, 2'd3, 16'h5A5A, 1, 1, 4'b1000, 3'd1, 0, 64'h5A5A_AAAA_CCCC_BBBB);

    rst_n = 1'b0;
    model_clear();
    do_reset();

    // Directed table
    for (int i = 0; i < 15; i++) begin
      apply(tv[i].v, tv[i].m, tv[i].d, tv[i].c);
      chk($sformatf("tv%0d_rdy", i), {63'd0, last_rdy}, {63'd0, tv[i].exp_rdy});
      chk($sformatf("tv%0d_full", i), {60'd0, full}, {60'd0, tv[i].exp_full});
      chk($sformatf("tv%0d_cnt", i), {61'd0, fill_count}, {61'd0, tv[i].exp_cnt});
      chk($sformatf("tv%0d_all_full", i), {63'd0, all_full}, {63'd0, (tv[i].exp_cnt == 3'd4)});
      chk($sformatf("tv%0d_done", i), {63'd0, done}, {63'd0, tv[i].exp_done});
      chk($sformatf("tv%0d_outs", i), {out3, out2, out1, out0}, tv[i].exp_outs);
    end

    // Out-of-order load with idle gaps: 1, 3, 0, 2
    do_reset();
    apply(1, 2'd1, 16'h0101, 0); chk("gap_cnt1", 64'(fill_count), 64'd1);
    apply(0, 2'd2, 16'hFFFF, 0); chk("gap_idle1", 64'(full), 64'h2);
    apply(1, 2'd3, 16'h0303, 0); chk("gap_cnt2", 64'(fill_count), 64'd2);
    apply(0, 2'd0, 16'hFFFF, 1); chk("gap_idle2", 64'(full), 64'hA);
    apply(1, 2'd0, 16'h0000, 0); chk("gap_cnt3", 64'(fill_count), 64'd3);
    chk("gap_no_done3", 64'(done), 64'd0);
    apply(0, 2'd2, 16'hFFFF, 0); chk("gap_idle3", 64'(full), 64'hB);
    apply(1, 2'd2, 16'h0202, 0); chk("gap_done", 64'(done), 64'd1);
    chk("gap_outs", {out3, out2, out1, out0}, 64'h0303_0202_0101_0000);
    apply(0, 2'd0, 16'h0000, 0); chk("gap_done_once", 64'(done), 64'd0);

    // Mid-cycle asynchronous reset while partially filled
    do_reset();
    apply(1, 2'd3, 16'h3030, 0);
    apply(1, 2'd0, 16'h0A0A, 0);
    apply(1, 2'd2, 16'h2020, 0);
    valid_r = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    @(posedge clk);
    #1;
    chk("async_hold_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    model_clear();
    pulses = 0;
    apply(1, 2'd2, 16'h1234, 0); if (done) pulses++;
    apply(1, 2'd0, 16'h5678, 0); if (done) pulses++;
    apply(1, 2'd1, 16'h9ABC, 0); if (done) pulses++;
    apply(1, 2'd3, 16'hDEF0, 0); if (done) pulses++;
    apply(0, 2'd0, 16'h0000, 0); if (done) pulses++;
    apply(1, 2'd1, 16'h7777, 0); if (done) pulses++;
    chk("refill_done_pulses", 64'(pulses), 64'd1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 16'($urandom),
            $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
